video_wb_arbiter: RTL and testbench

//  Shares the single Wishbone master port to external RAM between two requesters:
//  m0 = video_in_store (frame writes) and m1 = video_out fetch (frame reads).

---
 rtl/video_wb_pkg.sv | 15 +
 rtl/wb_rr_grant.sv | 67 ++++++
 rtl/video_wb_arbiter.sv | 117 +++++++++++
 tb/tb_video_wb_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/video_wb_pkg.sv
// Shared types and bus widths for the video Wishbone arbiter.
package video_wb_pkg;

  localparam int unsigned WB_AW   = 32;
  localparam int unsigned WB_DW   = 32;
  localparam int unsigned WB_SELW = 4;

  // Encoding doubles as the one-hot grant vector {OWN1,OWN0}.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    OWN0 = 2'b01,
    OWN1 = 2'b10
  } owner_t;

endpackage

// File: rtl/wb_rr_grant.sv
// Round-robin whole-cycle ownership FSM for two Wishbone requesters.
module wb_rr_grant
  import video_wb_pkg::*;
(
  input  logic       clk,
  input  logic       nRST,
  input  logic       req0,
  input  logic       req1,
  input  logic       hold0,
  input  logic       hold1,
  output logic [1:0] grant,
  output logic       release_c
);

  owner_t state_q;
  owner_t state_nxt;
  logic   last_q;
  logic   last_nxt;

  // State and last-owner registers; m0 wins the first tie after reset.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_nxt;
      last_q  <= last_nxt;
    end
  end

  // Next owner: tie goes to the master that did not own last; release hands over directly.
  always_comb begin
    state_nxt = state_q;
    last_nxt  = last_q;
    case (state_q)
      IDLE: begin
        if (req0 && req1) begin
          state_nxt = last_q ? OWN0 : OWN1;
        end else if (req0) begin
          state_nxt = OWN0;
        end else if (req1) begin
          state_nxt = OWN1;
        end
      end
      OWN0: begin
        if (!hold0) begin
          last_nxt  = 1'b0;
          state_nxt = req1 ? OWN1 : IDLE;
        end
      end
      OWN1: begin
        if (!hold1) begin
          last_nxt  = 1'b1;
          state_nxt = req0 ? OWN0 : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Grant vector straight from the state register; release flags an ownership change.
  always_comb begin
    grant     = 2'(state_q);
    release_c = ((state_q == OWN0) && !hold0) || ((state_q == OWN1) && !hold1);
  end

endmodule

// File: rtl/video_wb_arbiter.sv
// Two-master Wishbone arbiter (video store / video fetch) with slave-hang watchdog.
module video_wb_arbiter
  import video_wb_pkg::*;
#(
  parameter int unsigned TIMEOUT = 256,
  parameter int unsigned TO_W    = 9
) (
  input  logic               clk,
  input  logic               nRST,
  input  logic               m0_wb_CYC_I,
  input  logic               m0_wb_STB_I,
  input  logic               m0_wb_LOCK_I,
  input  logic               m0_wb_WE_I,
  input  logic [WB_SELW-1:0] m0_wb_SEL_I,
  input  logic [WB_AW-1:0]   m0_wb_ADR_I,
  input  logic [WB_DW-1:0]   m0_wb_DAT_I,
  output logic [WB_DW-1:0]   m0_wb_DAT_O,
  output logic               m0_wb_ACK_O,
  output logic               m0_wb_ERR_O,
  input  logic               m1_wb_CYC_I,
  input  logic               m1_wb_STB_I,
  input  logic               m1_wb_LOCK_I,
  input  logic               m1_wb_WE_I,
  input  logic [WB_SELW-1:0] m1_wb_SEL_I,
  input  logic [WB_AW-1:0]   m1_wb_ADR_I,
  input  logic [WB_DW-1:0]   m1_wb_DAT_I,
  output logic [WB_DW-1:0]   m1_wb_DAT_O,
  output logic               m1_wb_ACK_O,
  output logic               m1_wb_ERR_O,
  output logic               s_wb_CYC_O,
  output logic               s_wb_STB_O,
  output logic               s_wb_LOCK_O,
  output logic               s_wb_WE_O,
  output logic [WB_SELW-1:0] s_wb_SEL_O,
  output logic [WB_AW-1:0]   s_wb_ADR_O,
  output logic [WB_DW-1:0]   s_wb_DAT_O,
  input  logic [WB_DW-1:0]   s_wb_DAT_I,
  input  logic               s_wb_ACK_I,
  input  logic               s_wb_ERR_I,
  output logic [1:0]         grant
);

  localparam logic            WD_EN   = (TIMEOUT != 32'd0);
  localparam logic [TO_W-1:0] WD_LAST = TO_W'(TIMEOUT - 32'd1);

  logic            release_c;
  logic            own_stb;
  logic            wd_fire;
  logic [TO_W-1:0] wd_q;

  wb_rr_grant u_grant (
    .clk       (clk),
    .nRST      (nRST),
    .req0      (m0_wb_CYC_I),
    .req1      (m1_wb_CYC_I),
    .hold0     (m0_wb_CYC_I | m0_wb_LOCK_I),
    .hold1     (m1_wb_CYC_I | m1_wb_LOCK_I),
    .grant     (grant),
    .release_c (release_c)
  );

  // Owner-to-slave mux; everything parks at zero while idle.
  always_comb begin
    s_wb_CYC_O  = 1'b0;
    s_wb_LOCK_O = 1'b0;
    s_wb_WE_O   = 1'b0;
    s_wb_SEL_O  = '0;
    s_wb_ADR_O  = '0;
    s_wb_DAT_O  = '0;
    own_stb     = 1'b0;
    if (grant[0]) begin
      s_wb_CYC_O  = m0_wb_CYC_I;
      s_wb_LOCK_O = m0_wb_LOCK_I;
      s_wb_WE_O   = m0_wb_WE_I;
      s_wb_SEL_O  = m0_wb_SEL_I;
      s_wb_ADR_O  = m0_wb_ADR_I;
      s_wb_DAT_O  = m0_wb_DAT_I;
      own_stb     = m0_wb_STB_I;
    end else if (grant[1]) begin
      s_wb_CYC_O  = m1_wb_CYC_I;
      s_wb_LOCK_O = m1_wb_LOCK_I;
      s_wb_WE_O   = m1_wb_WE_I;
      s_wb_SEL_O  = m1_wb_SEL_I;
      s_wb_ADR_O  = m1_wb_ADR_I;
      s_wb_DAT_O  = m1_wb_DAT_I;
      own_stb     = m1_wb_STB_I;
    end
  end

  // Watchdog fires on the TIMEOUT-th unanswered strobe cycle, suppressing STB that cycle.
  always_comb begin
    wd_fire    = WD_EN && own_stb && !s_wb_ACK_I && !s_wb_ERR_I && (wd_q == WD_LAST);
    s_wb_STB_O = own_stb && !wd_fire;
  end

  // Watchdog counter: runs only across consecutive unanswered strobes of one owner.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      wd_q <= '0;
    end else if (!WD_EN || !own_stb || s_wb_ACK_I || s_wb_ERR_I || wd_fire || release_c) begin
      wd_q <= '0;
    end else begin
      wd_q <= wd_q + TO_W'(1);
    end
  end

  // Slave responses go to the owner only; read data is broadcast.
  always_comb begin
    m0_wb_DAT_O = s_wb_DAT_I;
    m1_wb_DAT_O = s_wb_DAT_I;
    m0_wb_ACK_O = grant[0] && s_wb_ACK_I;
    m1_wb_ACK_O = grant[1] && s_wb_ACK_I;
    m0_wb_ERR_O = grant[0] && (s_wb_ERR_I || wd_fire);
    m1_wb_ERR_O = grant[1] && (s_wb_ERR_I || wd_fire);
  end

endmodule

// File: tb/tb_video_wb_arbiter.sv
// Directed bench for video_wb_arbiter: arbitration, burst integrity, lock, watchdog, reset.
module tb_video_wb_arbiter;
  import video_wb_pkg::*;

  logic               clk = 1'b0;
  logic               nRST;
  logic               m0_wb_CYC_I, m0_wb_STB_I, m0_wb_LOCK_I, m0_wb_WE_I;
  logic [WB_SELW-1:0] m0_wb_SEL_I;
  logic [WB_AW-1:0]   m0_wb_ADR_I;
  logic [WB_DW-1:0]   m0_wb_DAT_I, m0_wb_DAT_O;
  logic               m0_wb_ACK_O, m0_wb_ERR_O;
  logic               m1_wb_CYC_I, m1_wb_STB_I, m1_wb_LOCK_I, m1_wb_WE_I;
  logic [WB_SELW-1:0] m1_wb_SEL_I;
  logic [WB_AW-1:0]   m1_wb_ADR_I;
  logic [WB_DW-1:0]   m1_wb_DAT_I, m1_wb_DAT_O;
  logic               m1_wb_ACK_O, m1_wb_ERR_O;
  logic               s_wb_CYC_O, s_wb_STB_O, s_wb_LOCK_O, s_wb_WE_O;
  logic [WB_SELW-1:0] s_wb_SEL_O;
  logic [WB_AW-1:0]   s_wb_ADR_O;
  logic [WB_DW-1:0]   s_wb_DAT_O;
  logic [WB_DW-1:0]   s_wb_DAT_I;
  logic               s_wb_ACK_I, s_wb_ERR_I;
  logic [1:0]         grant;

  logic slv_ack_en;
  logic slv_err;
  int   n_checks = 0;
  int   n_fail   = 0;

  localparam logic [31:0] M0_BASE = 32'h1000_0000;
  localparam logic [31:0] M1_BASE = 32'h8000_0000;

  always #5 clk = ~clk;

  // Slave model: answers every cycle it sees CYC when enabled; ERR is driven directly.
  assign s_wb_ACK_I = slv_ack_en & s_wb_CYC_O;
  assign s_wb_ERR_I = slv_err;

  video_wb_arbiter #(.TIMEOUT(8), .TO_W(4)) dut (
    .clk          (clk),
    .nRST         (nRST),
    .m0_wb_CYC_I  (m0_wb_CYC_I),
    .m0_wb_STB_I  (m0_wb_STB_I),
    .m0_wb_LOCK_I (m0_wb_LOCK_I),
    .m0_wb_WE_I   (m0_wb_WE_I),
    .m0_wb_SEL_I  (m0_wb_SEL_I),
    .m0_wb_ADR_I  (m0_wb_ADR_I),
    .m0_wb_DAT_I  (m0_wb_DAT_I),
    .m0_wb_DAT_O  (m0_wb_DAT_O),
    .m0_wb_ACK_O  (m0_wb_ACK_O),
    .m0_wb_ERR_O  (m0_wb_ERR_O),
    .m1_wb_CYC_I  (m1_wb_CYC_I),
    .m1_wb_STB_I  (m1_wb_STB_I),
    .m1_wb_LOCK_I (m1_wb_LOCK_I),
    .m1_wb_WE_I   (m1_wb_WE_I),
    .m1_wb_SEL_I  (m1_wb_SEL_I),
    .m1_wb_ADR_I  (m1_wb_ADR_I),
    .m1_wb_DAT_I  (m1_wb_DAT_I),
    .m1_wb_DAT_O  (m1_wb_DAT_O),
    .m1_wb_ACK_O  (m1_wb_ACK_O),
    .m1_wb_ERR_O  (m1_wb_ERR_O),
    .s_wb_CYC_O   (s_wb_CYC_O),
    .s_wb_STB_O   (s_wb_STB_O),
    .s_wb_LOCK_O  (s_wb_LOCK_O),
    .s_wb_WE_O    (s_wb_WE_O),
    .s_wb_SEL_O   (s_wb_SEL_O),
    .s_wb_ADR_O   (s_wb_ADR_O),
    .s_wb_DAT_O   (s_wb_DAT_O),
    .s_wb_DAT_I   (s_wb_DAT_I),
    .s_wb_ACK_I   (s_wb_ACK_I),
    .s_wb_ERR_I   (s_wb_ERR_I),
    .grant        (grant)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic idle_masters();
    m0_wb_CYC_I = 1'b0; m0_wb_STB_I = 1'b0; m0_wb_LOCK_I = 1'b0; m0_wb_WE_I = 1'b0;
    m0_wb_SEL_I = '0;   m0_wb_ADR_I = '0;   m0_wb_DAT_I = '0;
    m1_wb_CYC_I = 1'b0; m1_wb_STB_I = 1'b0; m1_wb_LOCK_I = 1'b0; m1_wb_WE_I = 1'b0;
    m1_wb_SEL_I = '0;   m1_wb_ADR_I = '0;   m1_wb_DAT_I = '0;
  endtask

  task automatic do_reset();
    nRST = 1'b0;
    tick();
    tick();
    nRST = 1'b1;
  endtask

  // Hard stop so a stuck run still reports.
  initial begin
    #100000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

  initial begin
    int acks0;
    int acks1;
    idle_masters();
    slv_ack_en = 1'b1;
    slv_err    = 1'b0;
    s_wb_DAT_I = 32'hCAFE_0001;
    nRST       = 1'b0;
    #1;
    check_eq("rst_grant", 32'(grant), 32'h0);
    check_eq("rst_s_cyc", 32'(s_wb_CYC_O), 32'h0);
    check_eq("rst_m0_ack", 32'(m0_wb_ACK_O), 32'h0);
    do_reset();
    check_eq("rst_s_stb", 32'(s_wb_STB_O), 32'h0);
    check_eq("rst_s_adr", s_wb_ADR_O, 32'h0);

    // Test 1: m0 alone, 16-beat write burst
    m0_wb_CYC_I = 1'b1; m0_wb_STB_I = 1'b1; m0_wb_WE_I = 1'b1; m0_wb_SEL_I = 4'hF;
    m0_wb_ADR_I = M0_BASE; m0_wb_DAT_I = 32'hD000_0000;
    at_neg();
    check_eq("t1_latency_grant", 32'(grant), 32'h0);
    check_eq("t1_latency_cyc", 32'(s_wb_CYC_O), 32'h0);
    tick();
    acks0 = 0;
    acks1 = 0;
    for (int i = 0; i < 16; i++) begin
      m0_wb_ADR_I = M0_BASE + 32'(4 * i);
      m0_wb_DAT_I = 32'hD000_0000 + 32'(i);
      at_neg();
      check_eq("t1_grant", 32'(grant), 32'h1);
      check_eq("t1_adr", s_wb_ADR_O, M0_BASE + 32'(4 * i));
      if (i == 0) begin
        check_eq("t1_we", 32'(s_wb_WE_O), 32'h1);
        check_eq("t1_sel", 32'(s_wb_SEL_O), 32'hF);
        check_eq("t1_dat", s_wb_DAT_O, 32'hD000_0000);
        check_eq("t1_rdat_bcast", m0_wb_DAT_O, 32'hCAFE_0001);
      end
      acks0 += int'(m0_wb_ACK_O);
      acks1 += int'(m1_wb_ACK_O);
      tick();
    end
    m0_wb_CYC_I = 1'b0; m0_wb_STB_I = 1'b0;
    check_eq("t1_m0_acks", 32'(acks0), 32'd16);
    check_eq("t1_m1_acks", 32'(acks1), 32'd0);
    at_neg();
    check_eq("t1_rel_cyc", 32'(s_wb_CYC_O), 32'h0);
    check_eq("t1_rel_grant_held", 32'(grant), 32'h1);
    tick();
    at_neg();
    check_eq("t1_idle", 32'(grant), 32'h0);

    // Test 2: simultaneous requests, round-robin, ERR routing
    do_reset();
    m0_wb_CYC_I = 1'b1; m0_wb_STB_I = 1'b1;
    m1_wb_CYC_I = 1'b1; m1_wb_STB_I = 1'b1; m1_wb_ADR_I = M1_BASE;
    tick();
    at_neg();
    check_eq("t2_tie_m0", 32'(grant), 32'h1);
    check_eq("t2_m1_stall", 32'(m1_wb_ACK_O), 32'h0);
    tick();
    m0_wb_CYC_I = 1'b0; m0_wb_STB_I = 1'b0;
    at_neg();
    check_eq("t2_drop_held", 32'(grant), 32'h1);
    tick();
    slv_err = 1'b1;
    at_neg();
    check_eq("t2_handover", 32'(grant), 32'h2);
    check_eq("t2_m1_ack", 32'(m1_wb_ACK_O), 32'h1);
    check_eq("t2_m0_ack", 32'(m0_wb_ACK_O), 32'h0);
    check_eq("t2_m1_err", 32'(m1_wb_ERR_O), 32'h1);
    check_eq("t2_m0_err", 32'(m0_wb_ERR_O), 32'h0);
    check_eq("t2_m1_adr", s_wb_ADR_O, M1_BASE);
    tick();
    slv_err = 1'b0;
    m1_wb_CYC_I = 1'b0; m1_wb_STB_I = 1'b0;
    tick();
    m0_wb_CYC_I = 1'b1; m0_wb_STB_I = 1'b1;
    m1_wb_CYC_I = 1'b1; m1_wb_STB_I = 1'b1;
    at_neg();
    check_eq("t2_idle_before_tie", 32'(grant), 32'h0);
    tick();
    at_neg();
    check_eq("t2_tie2_m0", 32'(grant), 32'h1);
    idle_masters();
    tick();
    tick();

    // Test 3: m1 arrives mid-burst and must wait for the whole m0 cycle
    do_reset();
    m0_wb_CYC_I = 1'b1; m0_wb_STB_I = 1'b1; m0_wb_ADR_I = M0_BASE;
    m1_wb_ADR_I = M1_BASE + 32'h40; m1_wb_STB_I = 1'b1;
    tick();
    acks1 = 0;
    for (int i = 0; i < 16; i++) begin
      m0_wb_ADR_I = M0_BASE + 32'(4 * i);
      if (i == 4) m1_wb_CYC_I = 1'b1;
      at_neg();
      check_eq("t3_adr_m0", s_wb_ADR_O, M0_BASE + 32'(4 * i));
      acks1 += int'(m1_wb_ACK_O);
      tick();
    end
    m0_wb_CYC_I = 1'b0; m0_wb_STB_I = 1'b0;
    check_eq("t3_m1_no_ack", 32'(acks1), 32'd0);
    at_neg();
    check_eq("t3_still_m0", 32'(grant), 32'h1);
    tick();
    at_neg();
    check_eq("t3_grant_m1", 32'(grant), 32'h2);
    check_eq("t3_adr_m1", s_wb_ADR_O, M1_BASE + 32'h40);
    check_eq("t3_m1_ack", 32'(m1_wb_ACK_O), 32'h1);
    idle_masters();
    tick();
    tick();

    // Test 4: watchdog on hung m1 read (TIMEOUT=8)
    do_reset();
    slv_ack_en = 1'b0;
    s_wb_DAT_I = 32'hCAFE_0004;
    m1_wb_CYC_I = 1'b1; m1_wb_STB_I = 1'b1; m1_wb_ADR_I = M1_BASE + 32'h100;
    at_neg();
    check_eq("t4_idle", 32'(grant), 32'h0);
    tick();
    for (int k = 1; k <= 9; k++) begin
      at_neg();
      check_eq("t4_m1_err", 32'(m1_wb_ERR_O), (k == 8) ? 32'h1 : 32'h0);
      check_eq("t4_s_stb", 32'(s_wb_STB_O), (k == 8) ? 32'h0 : 32'h1);
      if (k == 8) begin
        check_eq("t4_m0_err", 32'(m0_wb_ERR_O), 32'h0);
        check_eq("t4_rdat_bcast", m1_wb_DAT_O, 32'hCAFE_0004);
      end
      tick();
    end
    idle_masters();
    slv_ack_en = 1'b1;
    tick();
    tick();

    // Test 5: m0 LOCK holds the grant across a CYC gap
    do_reset();
    m0_wb_CYC_I = 1'b1; m0_wb_STB_I = 1'b1; m0_wb_LOCK_I = 1'b1;
    tick();
    at_neg();
    check_eq("t5_grant_m0", 32'(grant), 32'h1);
    check_eq("t5_m0_ack", 32'(m0_wb_ACK_O), 32'h1);
    tick();
    m0_wb_CYC_I = 1'b0; m0_wb_STB_I = 1'b0;
    m1_wb_CYC_I = 1'b1; m1_wb_STB_I = 1'b1;
    for (int g = 0; g < 2; g++) begin
      at_neg();
      check_eq("t5_gap_grant", 32'(grant), 32'h1);
      check_eq("t5_gap_cyc", 32'(s_wb_CYC_O), 32'h0);
      check_eq("t5_gap_lock", 32'(s_wb_LOCK_O), 32'h1);
      check_eq("t5_gap_m1_ack", 32'(m1_wb_ACK_O), 32'h0);
      tick();
    end
    m0_wb_LOCK_I = 1'b0;
    at_neg();
    check_eq("t5_unlock_held", 32'(grant), 32'h1);
    tick();
    at_neg();
    check_eq("t5_grant_m1", 32'(grant), 32'h2);
    check_eq("t5_m1_ack", 32'(m1_wb_ACK_O), 32'h1);
    idle_masters();
    tick();
    tick();

    // Test 6: asynchronous reset in the middle of an m1 burst
    do_reset();
    m1_wb_CYC_I = 1'b1; m1_wb_STB_I = 1'b1; m1_wb_ADR_I = M1_BASE + 32'h200;
    tick();
    at_neg();
    check_eq("t6_beat1", 32'(m1_wb_ACK_O), 32'h1);
    tick();
    at_neg();
    check_eq("t6_beat2", 32'(m1_wb_ACK_O), 32'h1);
    tick();
    m0_wb_CYC_I = 1'b1; m0_wb_STB_I = 1'b1;
    #2;
    nRST = 1'b0;
    #1;
    check_eq("t6_rst_grant", 32'(grant), 32'h0);
    check_eq("t6_rst_cyc", 32'(s_wb_CYC_O), 32'h0);
    check_eq("t6_rst_m1_ack", 32'(m1_wb_ACK_O), 32'h0);
    check_eq("t6_rst_m1_err", 32'(m1_wb_ERR_O), 32'h0);
    check_eq("t6_rst_adr", s_wb_ADR_O, 32'h0);
    at_neg();
    #1;
    nRST = 1'b1;
    tick();
    at_neg();
    check_eq("t6_tie_m0", 32'(grant), 32'h1);
    idle_masters();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
